argmax_lane_packer: RTL and testbench
=====================================

Name: argmax_lane_packer

Overview:
- Upstream feeder for the serial-parallel signed argmax stage.
- Accepts a scalar stream of signed samples with a valid/ready handshake and frame-end marker.
- Packs samples into 16-lane words, one word per transfer, with first/last/lane-mask sideband so the argmax stage can accumulate across a frame.
- Pads short final words with the most-negative value, so padding never wins the argmax.

Parameters:
WIDTH, 8, sample bit width (signed two's complement)
ARGMAX_WIDTH, 8, width of the index space seen by the argmax stage; group counter is ARGMAX_WIDTH-4 bits
LANES, 16, lanes per output word; fixed at 16, must not be overridden

Ports:
clk  in  1  clock
rst  in  1  reset
enable  in  1  global advance; low freezes all state and forces in_ready=0
in_valid  in  1  sample valid
in_ready  out  1  packer can accept a sample this cycle
in_data  in  WIDTH  signed sample
in_last  in  1  sample is last of frame
out_valid  out  1  packed word valid
out_ready  in  1  consumer accepts word
out_lanes  out  16*WIDTH  lane k at bits [k*WIDTH +: WIDTH]; lane 0 = earliest sample
out_lane_mask  out  16  bit k set = lane k holds real data
out_first  out  1  word is first of frame
out_last  out  1  word is last of frame

Behaviour:
- Interface: single clock clk; rst is asynchronous, active-high.
- Reset (async assert, sync release):
  - out_valid=0, out_lanes=0, out_lane_mask=0, out_first=0, out_last=0.
  - Lane pointer=0, frame-start flag=1, group counter=0, state=FILL.
  - Reset mid-frame discards the partial word and any pending output word.
- Handshakes:
  - Input accepts on in_valid&in_ready&enable.
  - Output transfers on out_valid&out_ready.
  - out_* are registered and held stable while out_valid&!out_ready.
- Storage: fill register (16 lanes plus mask) and output register.
- State FILL:
  - in_ready=enable.
  - Each accepted sample is written to lane[ptr], sets mask[ptr], and increments ptr.
  - If ptr==15 or in_last, the word is complete:
    - If the output register is empty or draining this cycle, the word moves to the output register on the same edge. out_valid rises the next cycle.
    - Otherwise go to PEND.
- State PEND:
  - in_ready=0.
  - When the output register frees (out_valid=0, or out_ready=1 this cycle), transfer the word and return to FILL.
- Completion latency: 1 cycle from the accepting edge to out_valid.
- Sustained throughput: 1 sample/cycle with out_ready held high.
- Padding: on completion, every lane with mask=0 is set to -2^(WIDTH-1) (0x80 for WIDTH=8).
- Sideband:
  - out_first=1 on the first word after reset or after a word with out_last.
  - out_last=1 iff the completing sample had in_last.
  - A word can have both flags set (frame of <=16 samples).
  - A full word whose 16th sample carries in_last gets mask=0xFFFF and out_last=1; no empty trailer word is emitted.
- Group counter: increments on each output transfer, clears after a transfer with out_last, and wraps modulo 2^(ARGMAX_WIDTH-4).
- enable=0: no state changes and no acceptance. Output registers hold, including out_valid. An out_ready during enable=0 does not complete a transfer.
- Simultaneous events: completion on the same edge as an output transfer goes direct to the output register, with no PEND cycle.

Optional Feature:
- Macro: ARGMAX_LANE_PACKER_BASE_INDEX_EN.
- When defined:
  - Adds output out_base_index [ARGMAX_WIDTH-1:0] = group counter * 16, registered with the output word.
  - The downstream argmax adds its lane index to this to form a frame-absolute index.
  - Value wraps with the group counter.
- When undefined: the port and the sideband register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - ARGMAX_LANES=16 and ARGMAX_LANE_IDX_W=4.
  - Pad-value function min_signed(WIDTH).
  - Packed-word typedef: lanes, mask, first, last.
- One natural sub-module, argmax_lane_fill_reg: lane write, mask, pointer and padding. The parent holds the FSM and output register.

Test Plan:
- Reset then 16 samples 0..15, in_last on 15, out_ready=1 -> one word:
  - out_lanes lane k=k, mask=0xFFFF, out_first=1, out_last=1.
  - out_valid asserts 1 cycle after the 16th accept.
- Frame of 5 samples {3,-7,12,0,-1} with last -> lanes 0..4 as given, lanes 5..15=0x80, mask=0x001F, first=last=1.
- Frame of 40 samples ramp 0..39, out_ready=1 -> three words:
  - masks 0xFFFF, 0xFFFF, 0x00FF.
  - first flag only on word 0, last flag only on word 2.
  - With ARGMAX_LANE_PACKER_BASE_INDEX_EN: base indices 0, 16, 32.
- Backpressure: out_ready=0 across a second word's completion:
  - Enters PEND and in_ready drops.
  - Output word 1 is held unchanged.
  - Raising out_ready transfers word 1, and word 2 appears the next cycle; no sample lost.
- Assert rst after 7 of 16 samples, then send a fresh 16-sample frame -> the first word contains only the new frame's samples, out_first=1.
- enable=0 for 3 cycles mid-frame with in_valid=1 -> no accepts, pointer frozen; the packed word is identical to the same stream sent without the stall.

Source files
------------

// File: rtl/argmax_lane_packer_pkg.sv
// Shared constants, FSM state type, word sideband type and pad-value helper
// for the argmax lane packer.
package argmax_lane_packer_pkg;

  localparam int ARGMAX_LANES      = 16;
  localparam int ARGMAX_LANE_IDX_W = 4;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PEND = 1'b1
  } pack_state_e;

  // Lanes are carried as a flat vector alongside this, since their width follows WIDTH.
  typedef struct packed {
    logic [ARGMAX_LANES-1:0] mask;
    logic                    first;
    logic                    last;
  } argmax_word_side_t;

  // Most-negative two's complement value for the given width; callers slice to width.
  function automatic logic [63:0] min_signed(input int width);
    return 64'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/argmax_lane_fill_reg.sv
// Fill register: lane write, lane mask, write pointer and padding of unfilled lanes.
// The word view merges the sample being written this cycle so completion can load it directly.
module argmax_lane_fill_reg
  import argmax_lane_packer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr,
  input  logic                            clr,
  input  logic [WIDTH-1:0]                data,
  output logic [ARGMAX_LANES*WIDTH-1:0]   word_lanes,
  output logic [ARGMAX_LANES-1:0]         word_mask,
  output logic                            ptr_last
);

  localparam logic [WIDTH-1:0] PAD = WIDTH'(min_signed(WIDTH));

  logic [ARGMAX_LANES-1:0][WIDTH-1:0] lanes_q;
  logic [ARGMAX_LANES-1:0]            mask_q;
  logic [ARGMAX_LANE_IDX_W-1:0]       ptr_q;

  assign ptr_last = (ptr_q == {ARGMAX_LANE_IDX_W{1'b1}});

  always_comb begin
    word_mask = mask_q;
    if (wr) word_mask[ptr_q] = 1'b1;
    word_lanes = '0;
    for (int k = 0; k < ARGMAX_LANES; k++) begin
      if (!word_mask[k])
        word_lanes[k*WIDTH +: WIDTH] = PAD;
      else if (wr && (ptr_q == ARGMAX_LANE_IDX_W'(k)))
        word_lanes[k*WIDTH +: WIDTH] = data;
      else
        word_lanes[k*WIDTH +: WIDTH] = lanes_q[k];
    end
  end

  // Clear wins over write: a completing sample leaves through word_lanes on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
    end else if (clr) begin
      mask_q  <= '0;
      ptr_q   <= '0;
    end else if (wr) begin
      lanes_q[ptr_q] <= data;
      mask_q[ptr_q]  <= 1'b1;
      ptr_q          <= ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/argmax_lane_packer.sv
// Packs a scalar signed sample stream into 16-lane words with first/last/mask sideband.
// Optional out_base_index port enabled by defining ARGMAX_LANE_PACKER_BASE_INDEX_EN.
//
// state   | meaning
// ST_FILL | accepting samples into the fill register
// ST_PEND | fill word complete, waiting for the output register to free
module argmax_lane_packer
  import argmax_lane_packer_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int ARGMAX_WIDTH = 8,
  parameter int LANES        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_lanes,
  output logic [LANES-1:0]         out_lane_mask,
  output logic                     out_first,
  output logic                     out_last
`ifdef ARGMAX_LANE_PACKER_BASE_INDEX_EN
  , output logic [ARGMAX_WIDTH-1:0] out_base_index
`endif
);

  localparam int GRP_W = ARGMAX_WIDTH - ARGMAX_LANE_IDX_W;

  pack_state_e       state;
  logic [GRP_W-1:0]  grp_q;
  logic [GRP_W-1:0]  grp_next;
  logic              frame_start_q;
  logic              pend_last_q;

  logic                          accept;
  logic                          xfer;
  logic                          out_free;
  logic                          complete;
  logic                          load;
  logic                          word_last;
  logic [LANES*WIDTH-1:0]        fill_lanes;
  logic [LANES-1:0]              fill_mask;
  logic                          ptr_last;
  argmax_word_side_t             side;

  assign in_ready  = enable && (state == ST_FILL);
  assign accept    = in_valid && in_ready;
  assign xfer      = enable && out_valid && out_ready;
  assign out_free  = !out_valid || out_ready;
  assign complete  = accept && (ptr_last || in_last);
  assign word_last = (state == ST_PEND) ? pend_last_q : in_last;
  assign load      = enable && out_free && (complete || (state == ST_PEND));
  assign grp_next  = xfer ? (out_last ? '0 : grp_q + 1'b1) : grp_q;

  assign side.mask  = fill_mask;
  assign side.first = frame_start_q;
  assign side.last  = word_last;

  argmax_lane_fill_reg #(
    .WIDTH (WIDTH)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .wr         (accept),
    .clr        (load),
    .data       (in_data),
    .word_lanes (fill_lanes),
    .word_mask  (fill_mask),
    .ptr_last   (ptr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_FILL;
      grp_q          <= '0;
      frame_start_q  <= 1'b1;
      pend_last_q    <= 1'b0;
      out_valid      <= 1'b0;
      out_lanes      <= '0;
      out_lane_mask  <= '0;
      out_first      <= 1'b0;
      out_last       <= 1'b0;
`ifdef ARGMAX_LANE_PACKER_BASE_INDEX_EN
      out_base_index <= '0;
`endif
    end else if (enable) begin
      if (xfer) begin
        out_valid <= 1'b0;
        grp_q     <= grp_next;
      end
      if (load) begin
        out_valid      <= 1'b1;
        out_lanes      <= fill_lanes;
        out_lane_mask  <= side.mask;
        out_first      <= side.first;
        out_last       <= side.last;
        frame_start_q  <= side.last;
        state          <= ST_FILL;
`ifdef ARGMAX_LANE_PACKER_BASE_INDEX_EN
        // Base follows any transfer on this same edge, so it tracks grp_next.
        out_base_index <= {grp_next, {ARGMAX_LANE_IDX_W{1'b0}}};
`endif
      end else if (complete) begin
        state       <= ST_PEND;
        pend_last_q <= in_last;
      end
    end
  end

endmodule

// File: tb/tb_argmax_lane_packer.sv
// Randomized and directed bench for argmax_lane_packer with a queue-based word model.
module tb_argmax_lane_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_lanes;
  logic [15:0]  out_lane_mask;
  logic         out_first;
  logic         out_last;
`ifdef ARGMAX_LANE_PACKER_BASE_INDEX_EN
  logic [7:0]   out_base_index;
`endif

  argmax_lane_packer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_lanes     (out_lanes),
    .out_lane_mask (out_lane_mask),
    .out_first     (out_first),
    .out_last      (out_last)
`ifdef ARGMAX_LANE_PACKER_BASE_INDEX_EN
    , .out_base_index (out_base_index)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [127:0] lanes;
    logic [15:0]  mask;
    logic         first;
    logic         last;
    logic [7:0]   base;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] cur_q[$];
  int         m_word_idx = 0;
  logic       m_first = 1'b1;
  bit         rand_mode = 0;

  // Reference model: group accepted samples into words of up to 16, closing early on last.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur_q.delete();
      m_word_idx = 0;
      m_first = 1'b1;
    end else if (enable) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_word", 1, 0);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check_eq("xfer_lanes", out_lanes, w.lanes);
          check_eq("xfer_mask", out_lane_mask, w.mask);
          check_eq("xfer_first", out_first, w.first);
          check_eq("xfer_last", out_last, w.last);
`ifdef ARGMAX_LANE_PACKER_BASE_INDEX_EN
          check_eq("xfer_base", out_base_index, w.base);
`endif
        end
      end
      if (in_valid && in_ready) begin
        cur_q.push_back(in_data);
        if (cur_q.size() == 16 || in_last) begin
          word_t w;
          w.lanes = {16{8'h80}};
          for (int k = 0; k < cur_q.size(); k++) w.lanes[k*8 +: 8] = cur_q[k];
          w.mask  = 16'((17'd1 << cur_q.size()) - 17'd1);
          w.first = m_first;
          w.last  = in_last;
          w.base  = 8'((m_word_idx % 16) * 16);
          exp_q.push_back(w);
          m_word_idx = in_last ? 0 : m_word_idx + 1;
          m_first = in_last;
          cur_q.delete();
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_mode) begin
      out_ready = ($urandom % 4) != 0;
      enable    = ($urandom % 8) != 0;
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (in_ready && enable) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) check_eq("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0]   t2 [5];
  logic [7:0]   s6 [10];
  logic [127:0] snap;
  logic [127:0] ref_lanes;
  logic [15:0]  ref_mask;

  initial begin
    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    idle(2);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_lanes", out_lanes, 0);
    check_eq("rst_mask", out_lane_mask, 0);
    check_eq("rst_first", out_first, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    idle(1);

    // Full 16-sample frame
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check_eq("t1_pre_valid", out_valid, 0);
      send(8'(i), i == 15);
    end
    check_eq("t1_latency", out_valid, 1);
    check_eq("t1_lane5", out_lanes[47:40], 5);
    check_eq("t1_lane15", out_lanes[127:120], 15);
    check_eq("t1_mask", out_lane_mask, 16'hFFFF);
    check_eq("t1_first", out_first, 1);
    check_eq("t1_last", out_last, 1);
    idle(3);

    // Short frame padded with most-negative value
    t2 = '{8'd3, 8'hF9, 8'd12, 8'd0, 8'hFF};
    for (int i = 0; i < 5; i++) send(t2[i], i == 4);
    check_eq("t2_lane1", out_lanes[15:8], 8'hF9);
    check_eq("t2_lane4", out_lanes[39:32], 8'hFF);
    check_eq("t2_lane5_pad", out_lanes[47:40], 8'h80);
    check_eq("t2_lane15_pad", out_lanes[127:120], 8'h80);
    check_eq("t2_mask", out_lane_mask, 16'h001F);
    check_eq("t2_first", out_first, 1);
    check_eq("t2_last", out_last, 1);
    idle(3);

    // 40-sample ramp: three words
    for (int i = 0; i < 40; i++) send(8'(i), i == 39);
    check_eq("t3_mask", out_lane_mask, 16'h00FF);
    check_eq("t3_first", out_first, 0);
    check_eq("t3_last", out_last, 1);
`ifdef ARGMAX_LANE_PACKER_BASE_INDEX_EN
    check_eq("t3_base", out_base_index, 8'd32);
`endif
    idle(3);

    // Backpressure across a second completion
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(100 + i), 1'b0);
    snap = out_lanes;
    check_eq("bp_w1_valid", out_valid, 1);
    for (int i = 16; i < 32; i++) send(8'(100 + i), 1'b0);
    idle(2);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_hold", out_lanes, snap);
    check_eq("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    idle(1);
    check_eq("bp_w2_valid", out_valid, 1);
    check_eq("bp_w2_lane0", out_lanes[7:0], 8'd116);
    check_eq("bp_w2_lane15", out_lanes[127:120], 8'd131);
    check_eq("bp_resume_ready", in_ready, 1);
    send(8'd132, 1'b1);
    idle(3);

    // Reset mid-frame
    for (int i = 0; i < 7; i++) send(8'(200 + i), 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check_eq("rst_mid_valid", out_valid, 0);
    for (int i = 0; i < 16; i++) send(8'(i * 3), i == 15);
    check_eq("rst_mid_lane0", out_lanes[7:0], 8'd0);
    check_eq("rst_mid_lane6", out_lanes[55:48], 8'd18);
    check_eq("rst_mid_first", out_first, 1);
    check_eq("rst_mid_mask", out_lane_mask, 16'hFFFF);
    idle(3);

    // Enable stall must not change the packed word
    for (int i = 0; i < 10; i++) s6[i] = 8'($urandom);
    for (int i = 0; i < 10; i++) send(s6[i], i == 9);
    ref_lanes = out_lanes;
    ref_mask  = out_lane_mask;
    idle(3);
    for (int i = 0; i < 4; i++) send(s6[i], 1'b0);
    enable = 1'b0; in_valid = 1'b1; in_data = s6[4];
    for (int c = 0; c < 3; c++) begin
      idle(1);
      check_eq("stall_in_ready", in_ready, 0);
    end
    enable = 1'b1;
    for (int i = 4; i < 10; i++) send(s6[i], i == 9);
    check_eq("stall_lanes", out_lanes, ref_lanes);
    check_eq("stall_mask", out_lane_mask, ref_mask);
    idle(3);

    // Randomized frames with random backpressure, enable drops and input gaps
    rand_mode = 1;
    for (int f = 0; f < 12; f++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        if (($urandom % 3) == 0) idle($urandom_range(1, 2));
        send(8'($urandom), i == len - 1);
      end
    end
    rand_mode = 0;
    idle(1);
    enable = 1'b1;
    out_ready = 1'b1;
    idle(12);
    check_eq("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
